// File: rtl/imem_boot_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader: FSM encoding,
// frame field widths and the running checksum update.
package imem_boot_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;
  localparam int LANE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  function automatic logic [CSUM_W-1:0] csum_next(input logic [CSUM_W-1:0] csum,
                                                  input logic [BYTE_W-1:0] data);
    return csum ^ data;
  endfunction

  function automatic logic is_loading(input state_e st);
    logic res;
    case (st)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: res = 1'b1;
      default:                                 res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word and flags the byte
// that completes it.
module imem_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  // Only the first three bytes are stored; the fourth completes the word in flight.
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;

  // Lane counter and shift register next state
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear_i) begin
      lane_d  = {LANE_W{1'b0}};
      shift_d = {(WORD_W-BYTE_W){1'b0}};
    end else if (byte_valid_i) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {byte_i, shift_q[WORD_W-BYTE_W-1:BYTE_W]};
    end else begin
      lane_d  = lane_q;
      shift_d = shift_q;
    end
  end

  // Assembly state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q  <= {LANE_W{1'b0}};
      shift_q <= {(WORD_W-BYTE_W){1'b0}};
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

  assign word_o      = {byte_i, shift_q};
  assign word_done_o = byte_valid_i & ~clear_i & (lane_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image, writes it into
// the core's instruction memory and holds the core in reset until the image is good.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int PC_SIZE        = 10,
  parameter int ADDR_STEP      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               reset_IF_memory,
  output logic [WORD_W-1:0]  instruction_in,
  output logic [PC_SIZE-1:0] PC_write,
  output logic               wr_strobe,
  output logic               core_hold,
  output logic               done,
  output logic               error
);

  localparam int          MAX_WORDS = (2**PC_SIZE) / ADDR_STEP;
  localparam logic        TMO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [BYTE_W-1:0]  len_lo_q, len_lo_d;
  logic [LEN_W-1:0]   words_left_q, words_left_d;
  logic [PC_SIZE-1:0] addr_q, addr_d;
  logic [CSUM_W-1:0]  csum_q, csum_d;
  logic [31:0]        timer_q, timer_d;
  logic [WORD_W-1:0]  instr_q, instr_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic               strobe_q, strobe_d;
  logic               rx_ready_q, rif_q, core_hold_q, done_q, error_q;

  logic               accept_s, expire_s, asm_clear_s, asm_valid_s, word_done_s;
  logic [WORD_W-1:0]  word_s;
  logic [LEN_W-1:0]   len_s;

  assign accept_s    = rx_valid & rx_ready_q;
  assign expire_s    = TMO_EN & ~accept_s & (timer_q == TMO_LAST);
  assign asm_valid_s = accept_s & (state_q == ST_DATA);
  assign len_s       = {rx_data, len_lo_q};

  imem_word_assembler u_asm (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (asm_clear_s),
    .byte_valid_i(asm_valid_s),
    .byte_i      (rx_data),
    .word_o      (word_s),
    .word_done_o (word_done_s)
  );

  // FSM next state, counters, checksum and write-port next values
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    csum_d       = csum_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    strobe_d     = 1'b0;
    asm_clear_s  = 1'b0;
    if (is_loading(state_q)) begin
      timer_d = accept_s ? 32'd0 : timer_q + 32'd1;
    end else begin
      timer_d = 32'd0;
    end

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d      = ST_LEN_LO;
          words_left_d = {LEN_W{1'b0}};
          addr_d       = {PC_SIZE{1'b0}};
          csum_d       = {CSUM_W{1'b0}};
          timer_d      = 32'd0;
          asm_clear_s  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN_HI;
        end else if (expire_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          words_left_d = len_s;
          if (32'(len_s) > 32'(MAX_WORDS)) begin
            state_d = ST_ERR;
          end else if (len_s == 16'd0) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DATA;
          end
        end else if (expire_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          csum_d = csum_next(csum_q, rx_data);
          if (word_done_s) begin
            instr_d      = word_s;
            pc_d         = addr_q;
            strobe_d     = 1'b1;
            addr_d       = addr_q + PC_SIZE'(ADDR_STEP);
            words_left_d = words_left_q - 16'd1;
            state_d      = (words_left_q == 16'd1) ? ST_CHECK : ST_DATA;
          end else begin
            state_d = state_q;
          end
        end else if (expire_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = state_q;
        end
      end
      ST_CHECK: begin
        if (accept_s) begin
          state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
        end else if (expire_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs; status follows the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= {BYTE_W{1'b0}};
      words_left_q <= {LEN_W{1'b0}};
      addr_q       <= {PC_SIZE{1'b0}};
      csum_q       <= {CSUM_W{1'b0}};
      timer_q      <= 32'd0;
      instr_q      <= {WORD_W{1'b0}};
      pc_q         <= {PC_SIZE{1'b0}};
      strobe_q     <= 1'b0;
      rx_ready_q   <= 1'b0;
      rif_q        <= 1'b0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      csum_q       <= csum_d;
      timer_q      <= timer_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      strobe_q     <= strobe_d;
      rx_ready_q   <= is_loading(state_d);
      rif_q        <= is_loading(state_d);
      core_hold_q  <= (state_d != ST_DONE);
      done_q       <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERR);
    end
  end

  assign rx_ready        = rx_ready_q;
  assign reset_IF_memory = rif_q;
  assign instruction_in  = instr_q;
  assign PC_write        = pc_q;
  assign wr_strobe       = strobe_q;
  assign core_hold       = core_hold_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule
